// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 byte receiver: rx synchronizer, mid-bit timer and LSB-first shift register.
// byte_valid / frame_err pulse combinationally in the stop-bit sample cycle.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t     state, state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  // The start bit is re-checked half a bit in; every later sample is one full bit apart.
  assign tick      = (state == RX_START) ? (cnt == HALF) : (cnt == FULL);
  assign byte_data = shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_nxt = RX_START; else state_nxt = RX_IDLE;
      RX_START: if (tick) state_nxt = rx_sync ? RX_IDLE : RX_DATA; else state_nxt = RX_START;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP; else state_nxt = RX_DATA;
      RX_STOP:  if (tick) state_nxt = RX_IDLE; else state_nxt = RX_STOP;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == RX_STOP && tick) begin
      byte_valid = rx_sync;
      frame_err  = !rx_sync;
    end else begin
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (state == RX_IDLE || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_START) bit_idx <= 3'd0;
      else if (state == RX_DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == RX_DATA && tick) shreg <= {rx_sync, shreg[7:1]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: framed image -> 32-bit instruction-memory writes, core held in reset until done.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MAX_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state, state_nxt;
  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;
  logic [7:0]  len_lo;
  logic [15:0] len, word_cnt, len_rx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        len_too_big, word_done, last_word, csum_ok, csum_bad;
  logic        we_nxt, err_nxt, done_nxt, busy_nxt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_rx      = {byte_data, len_lo};
  assign len_too_big = len_rx > 16'(MAX_WORDS);
  assign word_done   = (state == DATA) && byte_valid && (byte_idx == 2'd3);
  assign last_word   = (word_cnt + 16'd1) == len;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
  assign csum_ok  = byte_valid && (byte_data == csum);
  assign csum_bad = byte_valid && (byte_data != csum);

  always_ff @(posedge clk) begin
    if (reset || state == HUNT) begin
      csum <= 8'd0;
    end else if (state == DATA && byte_valid) begin
      csum <= csum ^ byte_data;
    end
  end
`else
  localparam state_t AFTER_DATA = DONE;
  assign csum_ok  = 1'b0;
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (byte_valid && byte_data == SYNC_BYTE) state_nxt = LEN0; else state_nxt = HUNT;
      LEN0: if (frame_err) state_nxt = HUNT; else if (byte_valid) state_nxt = LEN1; else state_nxt = LEN0;
      LEN1: begin
        if (frame_err || (byte_valid && len_too_big)) state_nxt = HUNT;
        else if (byte_valid) state_nxt = (len_rx == 16'd0) ? AFTER_DATA : DATA;
        else state_nxt = LEN1;
      end
      DATA: begin
        if (frame_err) state_nxt = HUNT;
        else if (word_done && last_word) state_nxt = AFTER_DATA;
        else state_nxt = DATA;
      end
      CSUM: begin
        if (frame_err || csum_bad) state_nxt = HUNT;
        else if (csum_ok) state_nxt = DONE;
        else state_nxt = CSUM;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = HUNT;
    endcase
  end

  // done is timed one cycle after the final write, so it follows DONE rather than entering it.
  always_comb begin
    we_nxt   = word_done;
    err_nxt  = (state != DONE) &&
               (frame_err || (state == LEN1 && byte_valid && len_too_big) ||
                (state == CSUM && csum_bad));
    done_nxt = (state == DONE) || (state == CSUM && csum_ok);
    busy_nxt = state_nxt inside {LEN0, LEN1, DATA, CSUM};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= 8'd0;
      len        <= 16'd0;
      word_cnt   <= 16'd0;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
    end else begin
      imem_we   <= we_nxt;
      err       <= err_nxt;
      done      <= done_nxt;
      cpu_reset <= !done_nxt;
      busy      <= busy_nxt;
      if (we_nxt) begin
        imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
        imem_wdata <= {byte_data, word_buf};
      end
      if (state == LEN0 && byte_valid) len_lo <= byte_data;
      if (state == LEN1 && byte_valid) len <= len_rx;
      if (state_nxt == HUNT) word_cnt <= 16'd0;
      else if (word_done) word_cnt <= word_cnt + 16'd1;
      // The byte that carries us into DATA is LEN_HI, so indexing only counts while staying in DATA.
      if (state != DATA || state_nxt != DATA) byte_idx <= 2'd0;
      else if (byte_valid) byte_idx <= byte_idx + 2'd1;
      if (state == DATA && byte_valid) begin
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= byte_data;
          2'd1:    word_buf[15:8]  <= byte_data;
          2'd2:    word_buf[23:16] <= byte_data;
          default: word_buf        <= word_buf;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level reference model.
module tb_prog_loader;

  localparam int          CPB  = 4;
  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        imem_we, cpu_reset, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: sole writer of the observation log.
  logic [63:0] wr_q[$];
  int          err_cycles = 0;
  int          cr_bad = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          done_rise_cyc = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
    if (err === 1'b1) err_cycles++;
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
    if (cyc > 2 && cpu_reset === done) cr_bad++;
    cyc++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0]  bq[$];
  logic [31:0] wds[$];
  logic [63:0] exp_q[$];
  int          wr_base, err_base;

  task automatic mark();
    wr_base  = wr_q.size();
    err_base = err_cycles;
    bq.delete();
    wds.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One 8N1 character followed by two bit times of idle.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_glitch();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_all();
    foreach (bq[i]) send_byte(bq[i], 1'b1);
  endtask

  // Frame for the words in wds: expected writes and checksum derived from the frame rules.
  task automatic build_frame();
    logic [7:0]  cs;
    logic [31:0] n;
    logic [7:0]  b;
    cs = 8'h00;
    n  = 32'(wds.size());
    bq.push_back(8'hA5);
    bq.push_back(n[7:0]);
    bq.push_back(n[15:8]);
    foreach (wds[k]) begin
      for (int j = 0; j < 4; j++) begin
        b = wds[k][8*j +: 8];
        bq.push_back(b);
        cs = cs ^ b;
      end
      exp_q.push_back({BASE + 32'(4 * k), wds[k]});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    bq.push_back(cs);
`endif
  endtask

  task automatic check_writes(input string tag);
    check_val({tag, "_nwr"}, 32'(wr_q.size() - wr_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (wr_base + i) < wr_q.size(); i++) begin
      check_val({tag, "_addr"}, wr_q[wr_base + i][63:32], exp_q[i][63:32]);
      check_val({tag, "_data"}, wr_q[wr_base + i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic check_status(input string tag, input int n_err, input logic exp_done);
    repeat (6) @(negedge clk);
    check_val({tag, "_errcyc"}, 32'(err_cycles - err_base), 32'(n_err));
    check_val({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check_val({tag, "_cpurst"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_valid(input string tag);
    build_frame();
    send_all();
    check_status(tag, 0, 1'b1);
    check_writes(tag);
`ifndef PROG_LOADER_CHECKSUM_EN
    if (wds.size() > 0)
      check_val({tag, "_done_lat"}, 32'(done_rise_cyc - last_we_cyc), 32'd1);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_we", {31'd0, imem_we}, 32'd0);
    check_val("rst_addr", imem_addr, BASE);
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word program, then a second frame that must be ignored once done.
    mark();
    wds.push_back(32'h0000_0013);
    wds.push_back(32'h0000_006F);
    run_valid("prog2");
    mark();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_all();
    check_status("ignore", 0, 1'b1);
    check_writes("ignore");

    // Leading noise before the sync byte.
    do_reset();
    mark();
    send_byte(8'h3C, 1'b1);
    send_byte(8'h11, 1'b1);
    wds.push_back(32'hDEAD_BEEF);
    run_valid("noise");

    // Oversized length, then a good frame.
    do_reset();
    mark();
    bq = '{8'hA5, 8'h01, 8'h01};
    send_all();
    check_status("toolong", 1, 1'b0);
    check_writes("toolong");
    mark();
    wds.push_back($urandom);
    run_valid("after_toolong");

    // Stop bit low in the payload.
    do_reset();
    mark();
    bq = '{8'hA5, 8'h01, 8'h00};
    send_all();
    send_byte(8'h5A, 1'b0);
    check_status("framing", 1, 1'b0);
    check_writes("framing");

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    mark();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    exp_q.push_back({BASE, 32'h0403_0201});
    send_all();
    check_status("badcsum", 1, 1'b0);
    check_writes("badcsum");
`endif

    // Reset in the middle of the payload.
    do_reset();
    mark();
    bq = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34};
    send_all();
    check_val("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("midrst_cpurst", {31'd0, cpu_reset}, 32'd1);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    check_val("midrst_we", {31'd0, imem_we}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_writes("midrst");
    mark();
    wds.push_back($urandom);
    wds.push_back($urandom);
    run_valid("midrst_reload");

    // Random frames with optional noise and glitches; first one is the empty image.
    for (int it = 0; it < 6; it++) begin
      int n;
      int npre;
      logic [7:0] pb;
      do_reset();
      mark();
      npre = $urandom_range(0, 2);
      for (int p = 0; p < npre; p++) begin
        pb = 8'($urandom);
        if (pb == 8'hA5) pb = 8'h3C;
        send_byte(pb, 1'b1);
      end
      if ($urandom_range(0, 1) == 1) send_glitch();
      n = (it == 0) ? 0 : $urandom_range(1, 4);
      for (int w = 0; w < n; w++) wds.push_back($urandom);
      run_valid($sformatf("rand%0d", it));
    end

    check_val("cpurst_vs_done", 32'(cr_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
